alu_core_pipe: RTL and testbench
================================

ALU_CORE_PIPE -- requirements
Module: alu_core_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 Port i_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port i_reset, input, 1: the reset, synchronous and active-high.
REQ-004 Port i_valid, input, 1: the upstream request is present this cycle.
REQ-005 Port o_ready, output, 1: the block accepts a request this cycle.
REQ-006 Port i_ALUcontrol, input, 4: the operation code.
REQ-007 Port i_A, input, WIDTH: operand A.
REQ-008 Port i_B, input, WIDTH: operand B.
REQ-009 Port o_valid, output, 1: the result slot holds a valid result.
REQ-010 Port i_ready, input, 1: the downstream consumer takes the result this cycle.
REQ-011 Port o_result, output, WIDTH: the operation result.
REQ-012 Port o_zero, output, 1: high when o_result is all zeros.
REQ-013 Port o_overflow, output, 1: signed overflow on ADD or SUB.
REQ-014 Port o_illegal, output, 1: the operation code was not decoded.

Function
REQ-015 A request SHALL be accepted on a cycle when i_valid and o_ready are both high; a result SHALL be consumed on a cycle when o_valid and i_ready are both high.
REQ-016 The block SHALL be a two-stage pipeline: stage 1 (S1) registers the op code and operands; stage 2 (OUT) registers o_result and the flags computed from S1.
REQ-017 Latency without stall SHALL be 2 cycles from the accepting edge to o_valid high; back-to-back sustained throughput SHALL be 1 request per cycle while i_ready is held high.
REQ-018 Pipeline advance: advance = !o_valid || i_ready; o_ready SHALL equal !s1_valid || advance, combinationally.
REQ-019 When advance is high, OUT SHALL load from S1 (o_valid <= s1_valid), and S1 SHALL load from the input (s1_valid <= i_valid && o_ready).
REQ-020 When o_valid && !i_ready (stall), o_result, o_zero, o_overflow and o_illegal SHALL hold unchanged, and S1 SHALL hold if s1_valid is high.
REQ-021 Decode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B), 0111 SLT (signed A<B gives 1, else 0, zero-extended), 1100 NOR.
REQ-022 Any other code SHALL produce o_result=0 and o_illegal=1; the transaction SHALL still complete through the handshake.
REQ-023 ADD and SUB SHALL wrap modulo 2^WIDTH; o_overflow SHALL be set when the operand signs dictate that the signed result sign is wrong, and 0 for every other op.
REQ-024 SLT SHALL compare signed operands correctly even when A-B overflows.
REQ-025 o_zero SHALL be derived from the registered o_result and be valid whenever o_valid is high.
REQ-026 Data outputs are don't-care when o_valid is low, except after reset.
REQ-027 A simultaneous consume at OUT and accept at input in the same cycle SHALL lose no transaction and duplicate none.

Reset
REQ-028 When i_reset is high at a clock edge: s1_valid=0, o_valid=0, o_result=0, o_zero=1, o_overflow=0, o_illegal=0.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions; o_ready SHALL be 1 in the first cycle after reset.
REQ-030 Reset SHALL take priority over all handshake activity in the same cycle.

Verification
REQ-031 Basic: ADD with A=5, B=7 accepted at cycle 0 -> o_valid=1 at cycle 2, o_result=12, o_zero=0, o_overflow=0.
REQ-032 Overflow: ADD with A=0x7FFFFFFF, B=1 -> o_result=0x80000000, o_overflow=1; SUB with A=B=0x1234 -> o_result=0, o_zero=1.
REQ-033 SLT: A=0xFFFFFFFF (-1), B=1 -> 1; A=0x80000000, B=0x7FFFFFFF -> 1; A=1, B=-1 -> 0.
REQ-034 Backpressure: stream 4 requests with i_ready=0 for 3 cycles -> o_ready drops after 2 are held; all 4 results emerge in order, each exactly once.
REQ-035 Illegal: op=1111, A=3, B=4 -> o_result=0, o_illegal=1; the next legal AND (0xF0 & 0x3C) -> 0x30, o_illegal=0.
REQ-036 Reset asserted with 2 in-flight transactions -> next cycle o_valid=0, o_ready=1; no stale result appears afterward.

Source files
------------

// File: rtl/alu_core_pipe.sv
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// Ports: i_clk, i_reset (sync, active-high), i_valid/o_ready (request in),
//        i_ALUcontrol, i_A, i_B (operation), o_valid/i_ready (result out),
//        o_result, o_zero, o_overflow, o_illegal (result and flags).
module alu_core_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_ALUcontrol,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             advance;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic             ill_c;

    // OUT may take a new value when empty or being drained this cycle;
    // S1 may take a new request when empty or when it moves into OUT.
    assign advance = !o_valid || i_ready;
    assign o_ready = !s1_valid || advance;

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;

    // Signed overflow: result sign disagrees with what the operand signs imply.
    assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1])
                  && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1])
                  && (diff[WIDTH-1] != s1_a[WIDTH-1]);

    // Sign of A-B corrected by overflow gives a true signed less-than.
    assign slt = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        case (s1_op)
            OP_AND: res_c = s1_a & s1_b;
            OP_OR:  res_c = s1_a | s1_b;
            OP_ADD: begin
                res_c = sum;
                ovf_c = add_ovf;
            end
            OP_SUB: begin
                res_c = diff;
                ovf_c = sub_ovf;
            end
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR: res_c = ~(s1_a | s1_b);
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_op <= i_ALUcontrol;
                    s1_a  <= i_A;
                    s1_b  <= i_B;
                end
            end
            if (advance) begin
                o_valid <= s1_valid;
                // Only real transactions overwrite the result registers.
                if (s1_valid) begin
                    o_result   <= res_c;
                    o_overflow <= ovf_c;
                    o_illegal  <= ill_c;
                end
            end
        end
    end

    assign o_zero = (o_result == '0);

endmodule

// File: tb/tb_alu_core_pipe.sv
module tb_alu_core_pipe;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_ALUcontrol;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_overflow;
    logic        o_illegal;

    alu_core_pipe #(.WIDTH(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_ALUcontrol (i_ALUcontrol),
        .i_A          (i_A),
        .i_B          (i_B),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_overflow   (o_overflow),
        .o_illegal    (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errs   = 0;
    int   n_acc  = 0;
    int   n_con  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, range test for overflow.
    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   m;
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        m.res = 32'd0;
        m.ovf = 1'b0;
        m.ill = 1'b0;
        case (op)
            4'd0:  m.res = a & b;
            4'd1:  m.res = a | b;
            4'd2: begin
                s = sa + sb;
                m.res = s[31:0];
                m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s = sa - sb;
                m.res = s[31:0];
                m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  m.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: m.res = ~(a | b);
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    // One clock: observe handshake mid-cycle, update scoreboard, cross edge.
    task automatic tick();
        exp_t e;
        logic acc;
        logic con;
        @(negedge i_clk);
        #1;
        if (i_reset) begin
            q.delete();
        end else begin
            chk("ready", o_ready, (q.size() < 2) || i_ready);
            chk("stale", o_valid && (q.size() == 0), 1'b0);
            acc = i_valid && o_ready;
            con = o_valid && i_ready;
            if (con && q.size() > 0) begin
                e = q.pop_front();
                n_con++;
                chk("res", o_result, e.res);
                chk("zero", o_zero, e.res == 32'd0);
                chk("ovf", o_overflow, e.ovf);
                chk("ill", o_illegal, e.ill);
            end
            if (acc) begin
                q.push_back(model(i_ALUcontrol, i_A, i_B));
                n_acc++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int n;
        i_valid = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while ((q.size() > 0 || o_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // Single request with no stall: latency and explicit expected values.
    task automatic run1(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf,
                        input logic ill);
        i_ready      = 1'b1;
        i_valid      = 1'b1;
        i_ALUcontrol = op;
        i_A          = a;
        i_B          = b;
        tick();
        i_valid = 1'b0;
        chk({tag, "_lat1"}, o_valid, 1'b0);
        tick();
        chk({tag, "_lat2"}, o_valid, 1'b1);
        chk({tag, "_res"}, o_result, res);
        chk({tag, "_zero"}, o_zero, res == 32'd0);
        chk({tag, "_ovf"}, o_overflow, ovf);
        chk({tag, "_ill"}, o_illegal, ill);
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [0:6];
        int k;
        int n;
        int acc0;
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd0};

        i_reset      = 1'b1;
        i_valid      = 1'b1;
        i_ready      = 1'b0;
        i_ALUcontrol = 4'd2;
        i_A          = 32'd1;
        i_B          = 32'd2;
        tick();
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_res", o_result, 32'd0);
        chk("rst_zero", o_zero, 1'b1);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_ill", o_illegal, 1'b0);

        run1("add", 4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        run1("addov", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
        run1("subz", 4'd6, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0);
        run1("subov", 4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run1("slt1", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        run1("slt2", 4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run1("slt3", 4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run1("nor", 4'd12, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF,
             1'b0, 1'b0);
        run1("or", 4'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        run1("illeg", 4'd15, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);
        run1("and", 4'd0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);

        // Sustained throughput: one accept per cycle with i_ready high.
        acc0 = n_acc;
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_ALUcontrol = 4'd2;
            i_A = i;
            i_B = 32'd100;
            tick();
        end
        chk("thru", n_acc - acc0, 8);
        drain();

        // Backpressure: four requests, consumer stalled three cycles.
        acc0 = n_acc;
        i_ready = 1'b0;
        i_valid = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            i_ALUcontrol = 4'd2;
            i_A = 32'd10 * k;
            i_B = 32'd1;
            if (n == 2)
                chk("bp_ready", o_ready, 1'b0);
            if (n == 3)
                i_ready = 1'b1;
            if (n == 3)
                i_A = 32'd10 * k;
            acc0 = n_acc;
            tick();
            if (n_acc != acc0)
                k++;
            n++;
        end
        chk("bp_all", k, 4);
        acc0 = n_con;
        drain();
        chk("bp_out", n_con - acc0, 2);

        // Reset with two transactions in flight.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_ALUcontrol = 4'd1;
        i_A = 32'h55;
        i_B = 32'hAA;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("mid_valid", o_valid, 1'b0);
        chk("mid_ready", o_ready, 1'b1);
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            i_valid = $urandom_range(0, 3) != 0;
            i_ready = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 5) == 0)
                i_ALUcontrol = 4'($urandom);
            else
                i_ALUcontrol = ops[$urandom_range(0, 6)];
            i_A = pick();
            i_B = pick();
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
